// File: rtl/probe_word_rx.sv
// Reassembles PORT_WIDTH-byte probe entries (LSB first) from a UART byte stream; word_valid 1 cycle after last byte.
// No back-pressure to the UART: entries completing while word_out is held unconsumed are dropped and flagged.
module probe_word_rx #(
  parameter int PORT_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              uart_rx_data,
  input  logic                    uart_rx_valid,
  output logic [PORT_WIDTH*8-1:0] word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [COUNT_WIDTH-1:0]  word_count,
  output logic                    overflow,
  output logic [COUNT_WIDTH-1:0]  desync_count,
  output logic                    busy
);

  localparam int IDX_W = (PORT_WIDTH > 1) ? $clog2(PORT_WIDTH) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [IDX_W-1:0]        index;
  logic [PORT_WIDTH*8-1:0] asm_reg;
  logic [PORT_WIDTH*8-1:0] asm_next;
  logic [CNT_W-1:0]        idle_cnt;
  logic                    complete;
  logic                    timeout;

  // Entry with the incoming byte merged in, so completion can deliver the final byte the same edge.
  always_comb begin
    asm_next = asm_reg;
    asm_next[8*index +: 8] = uart_rx_data;
  end

  assign complete = uart_rx_valid && (index == LAST_IDX);
  assign timeout  = !uart_rx_valid && (index != '0) && (idle_cnt == CNT_LIMIT);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      index        <= '0;
      asm_reg      <= '0;
      idle_cnt     <= '0;
      busy         <= 1'b0;
      desync_count <= '0;
    end else if (uart_rx_valid) begin
      asm_reg  <= asm_next;
      idle_cnt <= '0;
      if (complete) begin
        index <= '0;
        busy  <= 1'b0;
      end else begin
        index <= index + 1'b1;
        busy  <= 1'b1;
      end
    end else if (timeout) begin
      index    <= '0;
      asm_reg  <= '0;
      idle_cnt <= '0;
      busy     <= 1'b0;
      if (desync_count != '1)
        desync_count <= desync_count + 1'b1;
    end else if (index != '0) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

  // Output holding register; a completion may reload it in the same cycle it is consumed.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (complete) begin
      if (!word_valid || word_ready) begin
        word_out   <= asm_next;
        word_valid <= 1'b1;
        word_count <= word_count + 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_probe_word_rx.sv
// Directed bench for probe_word_rx with TIMEOUT_CYCLES=20; inputs driven and outputs sampled 1ns after posedge.
module tb_probe_word_rx;

  localparam int PW = 7;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [7:0]    uart_rx_data;
  logic          uart_rx_valid;
  logic [PW*8-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] word_count;
  logic          overflow;
  logic [CW-1:0] desync_count;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  probe_word_rx #(.PORT_WIDTH(PW), .TIMEOUT_CYCLES(20), .COUNT_WIDTH(CW)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_count   (word_count),
    .overflow     (overflow),
    .desync_count (desync_count),
    .busy         (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " word_out"}, 64'(word_out), 64'h0);
    check({tag, " word_valid"}, 64'(word_valid), 64'h0);
    check({tag, " word_count"}, 64'(word_count), 64'h0);
    check({tag, " overflow"}, 64'(overflow), 64'h0);
    check({tag, " desync"}, 64'(desync_count), 64'h0);
    check({tag, " busy"}, 64'(busy), 64'h0);
  endtask

  initial begin
    rst_in = 1'b1;
    uart_rx_data = 8'h00;
    uart_rx_valid = 1'b0;
    word_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_in = 1'b0;

    // Single entry, ready high, strobes 3 cycles apart
    word_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      send_byte(8'(i));
      if (i == 3) check("t1 busy mid", 64'(busy), 64'h1);
      if (i < 7) begin
        tick();
        tick();
      end
    end
    check("t1 valid", 64'(word_valid), 64'h1);
    check("t1 word", 64'(word_out), 64'h07060504030201);
    check("t1 count", 64'(word_count), 64'h1);
    check("t1 busy end", 64'(busy), 64'h0);
    tick();
    check("t1 valid pulse", 64'(word_valid), 64'h0);
    check("t1 word held", 64'(word_out), 64'h07060504030201);

    // Back-to-back entries with ready low: second dropped
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'(i));
    for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + i));
    check("t2 valid", 64'(word_valid), 64'h1);
    check("t2 word", 64'(word_out), 64'h06050403020100);
    check("t2 overflow", 64'(overflow), 64'h1);
    check("t2 count", 64'(word_count), 64'h1);
    word_ready = 1'b1;
    tick();
    check("t2 consumed", 64'(word_valid), 64'h0);
    check("t2 overflow sticky", 64'(overflow), 64'h1);

    // Accept-and-reload
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'(8'h20 + i));
    for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
    check("t3 hold first", 64'(word_out), 64'h26252423222120);
    word_ready = 1'b1;
    send_byte(8'h36);
    check("t3 valid", 64'(word_valid), 64'h1);
    check("t3 word", 64'(word_out), 64'h36353433323130);
    check("t3 overflow", 64'(overflow), 64'h0);
    check("t3 count", 64'(word_count), 64'h2);
    tick();
    check("t3 consumed", 64'(word_valid), 64'h0);

    // Timeout after 3 bytes
    do_reset();
    word_ready = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    for (int i = 0; i < 19; i++) tick();
    check("t4 busy before expiry", 64'(busy), 64'h1);
    check("t4 no desync yet", 64'(desync_count), 64'h0);
    tick();
    check("t4 busy dropped", 64'(busy), 64'h0);
    check("t4 desync", 64'(desync_count), 64'h1);
    check("t4 valid untouched", 64'(word_valid), 64'h0);
    for (int i = 0; i < 5; i++) tick();
    send_byte(8'hAA);
    for (int i = 1; i <= 6; i++) send_byte(8'(8'hA0 + i));
    check("t4 valid", 64'(word_valid), 64'h1);
    check("t4 word", 64'(word_out), 64'hA6A5A4A3A2A1AA);
    check("t4 desync held", 64'(desync_count), 64'h1);

    // Strobe on the expiry cycle wins; 00/FF are ordinary data
    do_reset();
    send_byte(8'hFF);
    send_byte(8'h00);
    for (int i = 0; i < 19; i++) tick();
    send_byte(8'h5A);
    check("t5 no desync", 64'(desync_count), 64'h0);
    check("t5 busy", 64'(busy), 64'h1);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hC3);
    send_byte(8'h3C);
    check("t5 word", 64'(word_out), 64'h3CC3FF005A00FF);
    check("t5 valid", 64'(word_valid), 64'h1);
    check("t5 desync after", 64'(desync_count), 64'h0);

    // Reset mid-entry while holding a word with overflow set
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'(8'h50 + i));
    for (int i = 0; i < 7; i++) send_byte(8'(8'h60 + i));
    for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i));
    check("t6 pre valid", 64'(word_valid), 64'h1);
    check("t6 pre overflow", 64'(overflow), 64'h1);
    rst_in = 1'b1;
    tick();
    check_all_zero("t6 reset");
    rst_in = 1'b0;
    for (int i = 1; i <= 7; i++) send_byte(8'(8'h70 + i));
    check("t6 word", 64'(word_out), 64'h77767574737271);
    check("t6 count", 64'(word_count), 64'h1);
    check("t6 valid", 64'(word_valid), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
